beeb_bus_target: RTL and testbench

- Memory-mapped mailbox that responds to 6502 bus cycles on the Beeb side, e.g. as a 1MHz-bus device in page &FC.
- Oversamples the bus Phi2 in the fast FPGA clock domain and decodes a 4-byte register window.
- Drives read data and captures write data with correct 6502 bus timing.
- Exposes two FIFOs to internal logic: host->Beeb (RX) and Beeb->host (TX), each with a valid/ready handshake.

---
 rtl/beeb_bus_pkg.sv | 24 ++
 rtl/bus_fifo.sv | 52 +++++
 rtl/beeb_bus_target.sv | 172 +++++++++++++++++
 tb/tb_beeb_bus_target.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/beeb_bus_pkg.sv
// Shared register map, status/control bit positions and bus FSM encoding
// for the Beeb 1MHz-bus mailbox.
package beeb_bus_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_COUNT   = 2'd3;

  localparam int STAT_RX_NE = 0;
  localparam int STAT_TX_NF = 1;
  localparam int STAT_OVF   = 2;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE_RD = 2'd1,
    ST_ACTIVE_WR = 2'd2,
    ST_SKIP      = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; pushes into a
// full FIFO and pops from an empty one are ignored.
module bus_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/beeb_bus_target.sv
// 6502 bus target: oversamples Phi2, decodes a 4-byte mailbox window and
// bridges it to host-side RX/TX FIFOs with valid/ready handshakes.
module beeb_bus_target
  import beeb_bus_pkg::*;
#(
  parameter logic [15:0] BASE            = 16'hFCF0,
  parameter int          FIFO_DEPTH_LOG2 = 4,
  parameter int          NSYNC           = 2,
  parameter int          SAMPLE_BACK     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Phi2,
  input  logic [15:0] Addr,
  input  logic        R_W_n,
  input  logic [7:0]  Data_in,
  output logic [7:0]  Data_out,
  output logic        Data_oe,
  output logic        IRQ,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int HIST = NSYNC + SAMPLE_BACK;
  localparam int CW   = FIFO_DEPTH_LOG2 + 1;

  function automatic logic [3:0] sat4(input logic [CW-1:0] c);
    return (c > CW'(15)) ? 4'hF : 4'(c);
  endfunction

  logic [NSYNC-1:0] phi_sync;
  logic [16:0]      cyc_hist [HIST];
  logic [7:0]       dat_hist [HIST];
  logic             rise, fall;
  logic [15:0]      addr_at_rise;
  logic             rnw_at_rise;
  logic             hit;

  bus_state_e state, state_nxt;
  logic [1:0] reg_sel;
  logic       rd_load_p0;
  logic       rd_pop_ok;
  logic [1:0] ctrl;
  logic       overflow;
  logic [7:0] rd_mux;
  logic       rd_commit, wr_commit;

  logic          rx_full, rx_empty, rx_push, rx_pop;
  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_count, tx_count;

  // Synchroniser and bus history; not reset so a reset mid-Phi2-high cannot fake a rise
  always_ff @(posedge clock) begin
    phi_sync    <= {phi_sync[NSYNC-2:0], Phi2};
    cyc_hist[0] <= {R_W_n, Addr};
    dat_hist[0] <= Data_in;
    for (int i = 1; i < HIST; i++) begin
      cyc_hist[i] <= cyc_hist[i-1];
      dat_hist[i] <= dat_hist[i-1];
    end
  end

  assign rise         = phi_sync[NSYNC-2] & ~phi_sync[NSYNC-1];
  assign fall         = ~phi_sync[NSYNC-2] & phi_sync[NSYNC-1];
  assign addr_at_rise = cyc_hist[NSYNC-1][15:0];
  assign rnw_at_rise  = cyc_hist[NSYNC-1][16];
  assign hit          = (addr_at_rise[15:2] == BASE[15:2]);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rise) begin
      if (!hit)             state_nxt = ST_SKIP;
      else if (rnw_at_rise) state_nxt = ST_ACTIVE_RD;
      else                  state_nxt = ST_ACTIVE_WR;
    end else if (fall && state != ST_IDLE) begin
      state_nxt = ST_IDLE;
    end
  end

  assign rd_commit = fall & (state == ST_ACTIVE_RD);
  assign wr_commit = fall & (state == ST_ACTIVE_WR);

  always_comb begin
    rd_mux = 8'h00;
    case (reg_sel)
      REG_DATA:    if (!rx_empty) rd_mux = rx_head;
      REG_STATUS: begin
        rd_mux[STAT_RX_NE] = ~rx_empty;
        rd_mux[STAT_TX_NF] = ~tx_full;
        rd_mux[STAT_OVF]   = overflow;
      end
      REG_CONTROL: begin
        rd_mux[CTRL_RX_IE] = ctrl[CTRL_RX_IE];
        rd_mux[CTRL_TX_IE] = ctrl[CTRL_TX_IE];
      end
      default:     rd_mux = {sat4(rx_count), sat4(tx_count)};
    endcase
  end

  // Read data is frozen one clock after rise; side effects land on fall
  always_ff @(posedge clock) begin
    if (reset) begin
      reg_sel    <= REG_DATA;
      rd_load_p0 <= 1'b0;
      rd_pop_ok  <= 1'b0;
      Data_oe    <= 1'b0;
      Data_out   <= 8'h00;
      ctrl       <= 2'b00;
      overflow   <= 1'b0;
      IRQ        <= 1'b0;
    end else begin
      rd_load_p0 <= rise & hit & rnw_at_rise;
      if (rise) begin
        reg_sel   <= addr_at_rise[1:0];
        rd_pop_ok <= 1'b0;
        Data_oe   <= 1'b0;
      end else if (rd_load_p0) begin
        Data_out  <= rd_mux;
        rd_pop_ok <= (reg_sel == REG_DATA) & ~rx_empty;
        Data_oe   <= 1'b1;
      end else if (fall) begin
        Data_oe   <= 1'b0;
      end
      if (wr_commit && reg_sel == REG_CONTROL) ctrl <= dat_hist[HIST-1][1:0];
      if (wr_commit && reg_sel == REG_DATA && tx_full)  overflow <= 1'b1;
      else if (rd_commit && reg_sel == REG_STATUS)      overflow <= 1'b0;
      IRQ <= (ctrl[CTRL_RX_IE] & ~rx_empty) | (ctrl[CTRL_TX_IE] & tx_empty);
    end
  end

  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & ~rx_full;
  assign rx_pop   = rd_commit & rd_pop_ok;
  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_push  = wr_commit & (reg_sel == REG_DATA) & ~tx_full;

  bus_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  bus_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (dat_hist[HIST-1]),
    .pop       (tx_pop),
    .pop_data  (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

endmodule

// File: tb/tb_beeb_bus_target.sv
// Scoreboard bench for beeb_bus_target: stimulus queues expected bus reads and
// TX bytes, a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_beeb_bus_target;

  logic        clock = 1'b0;
  logic        reset;
  logic        Phi2;
  logic [15:0] Addr;
  logic        R_W_n;
  logic [7:0]  Data_in;
  logic [7:0]  Data_out;
  logic        Data_oe;
  logic        IRQ;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks = 0;
  int passed = 0;
  int oe_rises = 0;
  int snap;
  logic oe_prev = 1'b0;
  logic [7:0] rd_exp [$];
  logic [7:0] tx_exp [$];

  beeb_bus_target dut (
    .clock    (clock),
    .reset    (reset),
    .Phi2     (Phi2),
    .Addr     (Addr),
    .R_W_n    (R_W_n),
    .Data_in  (Data_in),
    .Data_out (Data_out),
    .Data_oe  (Data_oe),
    .IRQ      (IRQ),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #6 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: a read is presented when Data_oe rises, a TX byte on each handshake
  always @(negedge clock) begin
    if (!reset) begin
      if (Data_oe && !oe_prev) begin
        oe_rises++;
        if (rd_exp.size() == 0) begin
          checks++;
          $display("FAIL unexpected_read: Data_out %02h with no read expected", Data_out);
        end else begin
          check("bus_read", {24'h0, Data_out}, {24'h0, rd_exp.pop_front()});
        end
      end
      if (tx_valid && tx_ready) begin
        if (tx_exp.size() == 0) begin
          checks++;
          $display("FAIL unexpected_tx: tx_data %02h with no byte expected", tx_data);
        end else begin
          check("tx_byte", {24'h0, tx_data}, {24'h0, tx_exp.pop_front()});
        end
      end
    end
    oe_prev = Data_oe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_rise(input logic [15:0] a, input logic rw, input logic [7:0] d);
    Addr = a; R_W_n = rw; Data_in = d;
    tick(4);
    Phi2 = 1'b1;
    tick(10);
  endtask

  // Data_in goes to FF one clock after the Phi2 fall, after the hold window
  task automatic bus_fall(input int post);
    Phi2 = 1'b0;
    tick(1);
    Data_in = 8'hFF;
    if (post > 1) tick(post - 1);
  endtask

  task automatic bus_rd(input logic [15:0] a);
    bus_rise(a, 1'b1, 8'hEE);
    bus_fall(4);
  endtask

  task automatic bus_rd_exp(input logic [15:0] a, input logic [7:0] e);
    rd_exp.push_back(e);
    bus_rd(a);
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    bus_rise(a, 1'b0, d);
    bus_fall(4);
  endtask

  task automatic host_push(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_irq(input logic v, input int n, input string nm);
    int k = 0;
    while (IRQ !== v && k < n) begin
      tick(1);
      k++;
    end
    check(nm, {31'h0, IRQ}, {31'h0, v});
  endtask

  initial begin
    reset = 1'b1; Phi2 = 1'b0; Addr = 16'h0000; R_W_n = 1'b1; Data_in = 8'h00;
    rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
    tick(3);
    check("reset_Data_oe",  {31'h0, Data_oe},  32'h0);
    check("reset_Data_out", {24'h0, Data_out}, 32'h0);
    check("reset_IRQ",      {31'h0, IRQ},      32'h0);
    check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("reset_rx_ready", {31'h0, rx_ready}, 32'h1);
    reset = 1'b0;
    tick(2);

    // Host to Beeb path and STATUS
    host_push(8'hA5);
    host_push(8'h3C);
    bus_rd_exp(16'hFCF1, 8'h03);
    bus_rd_exp(16'hFCF0, 8'hA5);
    bus_rd_exp(16'hFCF0, 8'h3C);
    bus_rd_exp(16'hFCF1, 8'h02);

    // Single write, drained immediately
    tx_exp.push_back(8'h55);
    bus_wr(16'hFCF0, 8'h55);
    check("tx_valid_one_beat", {31'h0, tx_valid}, 32'h0);

    // Overflow: 17 writes into a 16-deep TX with the host stalled
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) tx_exp.push_back(8'(i));
      bus_wr(16'hFCF0, 8'(i));
    end
    bus_rd_exp(16'hFCF1, 8'h04);
    bus_rd_exp(16'hFCF1, 8'h00);
    bus_rd_exp(16'hFCF3, 8'h0F);
    tx_ready = 1'b1;
    tick(24);
    check("tx_drained", {31'h0, tx_valid}, 32'h0);

    // Interrupts
    bus_wr(16'hFCF2, 8'h01);
    bus_rd_exp(16'hFCF2, 8'h01);
    check("irq_rx_empty", {31'h0, IRQ}, 32'h0);
    host_push(8'h9A);
    wait_irq(1'b1, 2, "irq_rx_set");
    rd_exp.push_back(8'h9A);
    bus_rise(16'hFCF0, 1'b1, 8'hEE);
    bus_fall(1);
    wait_irq(1'b0, 2, "irq_rx_clear");
    tick(3);
    bus_wr(16'hFCF2, 8'hFF);
    bus_rd_exp(16'hFCF2, 8'h03);
    check("irq_tx_empty", {31'h0, IRQ}, 32'h1);
    bus_wr(16'hFCF2, 8'h00);
    check("irq_disabled", {31'h0, IRQ}, 32'h0);

    // Outside the window, and an empty DATA read
    host_push(8'h77);
    snap = oe_rises;
    bus_rd(16'hFCEF);
    bus_rd(16'hFCF4);
    bus_wr(16'hFCF4, 8'h5A);
    check("miss_no_oe", oe_rises, snap);
    bus_rd_exp(16'hFCF3, 8'h10);
    bus_rd_exp(16'hFCF0, 8'h77);
    bus_rd_exp(16'hFCF0, 8'h00);
    bus_rd_exp(16'hFCF3, 8'h00);

    // Reset in the middle of an active read
    tx_ready = 1'b0;
    bus_wr(16'hFCF0, 8'hC3);
    host_push(8'h11);
    host_push(8'h22);
    rd_exp.push_back(8'h11);
    bus_rise(16'hFCF0, 1'b1, 8'hEE);
    check("oe_before_reset", {31'h0, Data_oe}, 32'h1);
    reset = 1'b1;
    tick(1);
    check("rst_Data_oe",   {31'h0, Data_oe},  32'h0);
    check("rst_Data_out",  {24'h0, Data_out}, 32'h0);
    check("rst_tx_empty",  {31'h0, tx_valid}, 32'h0);
    check("rst_rx_ready",  {31'h0, rx_ready}, 32'h1);
    reset = 1'b0;
    bus_fall(4);
    tx_ready = 1'b1;
    tick(2);
    check("rst_tx_still_empty", {31'h0, tx_valid}, 32'h0);
    host_push(8'h33);
    bus_rd_exp(16'hFCF0, 8'h33);
    bus_rd_exp(16'hFCF3, 8'h00);
    tick(5);

    check("rd_queue_empty", rd_exp.size(), 32'h0);
    check("tx_queue_empty", tx_exp.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
